// File: rtl/noc_packet_injector_if.sv
// Bundle between the core/router side and one packet injector: request,
// payload stream, flit output and status. The injector uses the master modport.
interface noc_packet_injector_if #(
    parameter int ID_X_W  = 2,
    parameter int ID_Y_W  = 2,
    parameter int DATA_W  = 32,
    parameter int VC_NUM  = 2,
    parameter int MAX_LEN = 16
);
    localparam int VC_W   = $clog2(VC_NUM);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FLIT_W = 2 + VC_W + DATA_W;

    logic [ID_X_W-1:0] src_x;
    logic [ID_Y_W-1:0] src_y;

    logic              req_valid;
    logic              req_ready;
    logic [ID_X_W-1:0] req_dest_x;
    logic [ID_Y_W-1:0] req_dest_y;
    logic [LEN_W-1:0]  req_len;

    logic              pl_valid;
    logic              pl_ready;
    logic [DATA_W-1:0] pl_data;

    logic              flit_valid;
    logic              flit_ready;
    logic [VC_NUM-1:0] vc_ready;
    logic [FLIT_W-1:0] flit;

    logic [15:0]       tx_pkt_cnt;

    modport master (
        input  src_x, src_y,
        input  req_valid, req_dest_x, req_dest_y, req_len,
        output req_ready,
        input  pl_valid, pl_data,
        output pl_ready,
        output flit_valid, flit, tx_pkt_cnt,
        input  flit_ready, vc_ready
    );

    modport slave (
        output src_x, src_y,
        output req_valid, req_dest_x, req_dest_y, req_len,
        input  req_ready,
        output pl_valid, pl_data,
        input  pl_ready,
        input  flit_valid, flit, tx_pkt_cnt,
        output flit_ready, vc_ready
    );
endinterface

// File: rtl/noc_packet_injector.sv
// NoC local-port injector: turns a packet request plus payload word stream into
// head/body/tail flits on a round-robin chosen VC, held stable under back-pressure.
module noc_packet_injector #(
    parameter int ID_X_W  = 2,
    parameter int ID_Y_W  = 2,
    parameter int DATA_W  = 32,
    parameter int VC_NUM  = 2,
    parameter int MAX_LEN = 16
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    noc_packet_injector_if.master bus
);
    localparam int VC_W   = $clog2(VC_NUM);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int FLIT_W = 2 + VC_W + DATA_W;
    localparam int HEAD_W = 2 * ID_X_W + 2 * ID_Y_W + LEN_W;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    typedef enum logic [1:0] {IDLE, ALLOC, SEND} state_e;

    state_e            state_q, state_d;
    logic [ID_X_W-1:0] dest_x_q, dest_x_d;
    logic [ID_Y_W-1:0] dest_y_q, dest_y_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [VC_W-1:0]   last_vc_q, last_vc_d;
    logic              flit_valid_q, flit_valid_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              pl_ready;
    logic              pl_hs;
    logic              flit_hs;
    logic              vc_found;
    logic [VC_W-1:0]   vc_pick;
    logic [VC_W-1:0]   vc_idx;
    logic [DATA_W-1:0] head_data;

    // A new payload word may only be loaded once the current flit has left or is leaving.
    assign pl_ready = (state_q == SEND) && (rem_q != '0) && (!flit_valid_q || bus.flit_ready);
    assign pl_hs    = bus.pl_valid && pl_ready;
    assign flit_hs  = flit_valid_q && bus.flit_ready;

    always_comb begin
        vc_found = 1'b0;
        vc_pick  = last_vc_q;
        vc_idx   = last_vc_q;
        // Wrap-around search starting one past the last granted VC.
        for (int i = 1; i <= VC_NUM; i++) begin
            vc_idx = last_vc_q + VC_W'(i);
            if (!vc_found && bus.vc_ready[vc_idx]) begin
                vc_found = 1'b1;
                vc_pick  = vc_idx;
            end
        end
    end

    always_comb begin
        head_data               = '0;
        head_data[HEAD_W-1:0]   = {len_q, bus.src_y, bus.src_x, dest_y_q, dest_x_q};
    end

    always_comb begin
        state_d      = state_q;
        dest_x_d     = dest_x_q;
        dest_y_d     = dest_y_q;
        len_d        = len_q;
        rem_d        = rem_q;
        last_vc_d    = last_vc_q;
        flit_valid_d = flit_valid_q;
        flit_d       = flit_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    dest_x_d = bus.req_dest_x;
                    dest_y_d = bus.req_dest_y;
                    len_d    = (bus.req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.req_len;
                    state_d  = ALLOC;
                end
            end
            ALLOC: begin
                if (vc_found) begin
                    last_vc_d    = vc_pick;
                    flit_valid_d = 1'b1;
                    flit_d       = {(len_q == '0) ? T_HT : T_HEAD, vc_pick, head_data};
                    rem_d        = len_q;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (pl_hs) begin
                    flit_valid_d = 1'b1;
                    flit_d       = {(rem_q == LEN_W'(1)) ? T_TAIL : T_BODY, last_vc_q, bus.pl_data};
                    rem_d        = rem_q - LEN_W'(1);
                end else if (flit_hs) begin
                    flit_valid_d = 1'b0;
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q      <= IDLE;
            dest_x_q     <= '0;
            dest_y_q     <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            last_vc_q    <= VC_W'(VC_NUM - 1);
            flit_valid_q <= 1'b0;
            flit_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            dest_x_q     <= dest_x_d;
            dest_y_q     <= dest_y_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            last_vc_q    <= last_vc_d;
            flit_valid_q <= flit_valid_d;
            flit_q       <= flit_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.pl_ready   = pl_ready;
    assign bus.flit_valid = flit_valid_q;
    assign bus.flit       = flit_q;
    assign bus.tx_pkt_cnt = cnt_q;
endmodule

// File: tb/tb_noc_packet_injector.sv
// Randomized bench for noc_packet_injector: a packet-level scoreboard predicts
// every flit (layout, VC round-robin, types) and checks handshake rules.
module tb_noc_packet_injector;
    localparam int ID_X_W  = 2;
    localparam int ID_Y_W  = 2;
    localparam int DATA_W  = 32;
    localparam int VC_NUM  = 2;
    localparam int MAX_LEN = 16;
    localparam int VC_W    = $clog2(VC_NUM);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int FLIT_W  = 2 + VC_W + DATA_W;

    logic noc_clk = 1'b0;
    logic noc_rst;
    always #5 noc_clk = ~noc_clk;

    noc_packet_injector_if #(.ID_X_W(ID_X_W), .ID_Y_W(ID_Y_W), .DATA_W(DATA_W),
                             .VC_NUM(VC_NUM), .MAX_LEN(MAX_LEN)) bus ();

    noc_packet_injector #(.ID_X_W(ID_X_W), .ID_Y_W(ID_Y_W), .DATA_W(DATA_W),
                          .VC_NUM(VC_NUM), .MAX_LEN(MAX_LEN)) dut (
        .noc_clk(noc_clk),
        .noc_rst(noc_rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [FLIT_W-1:0] exp_q[$];
    logic [DATA_W-1:0] pl_q[$];
    bit                pl_taken, bp, pl_rand, prev_stall;
    logic [FLIT_W-1:0] prev_flit;
    int cyc = 0;
    int flit_idx, pl_cnt, first_cyc, last_cyc, req_cyc, pkt_exp, rr_last;

    always @(posedge noc_clk) cyc <= cyc + 1;

    function automatic int rr_pick(input int last, input logic [VC_NUM-1:0] m);
        for (int i = 1; i <= VC_NUM; i++) begin
            int c;
            c = (last + i) % VC_NUM;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    // Monitor: sampled mid-cycle, so each sample describes the coming edge.
    initial begin
        prev_stall = 0;
        prev_flit  = '0;
        forever begin
            @(negedge noc_clk);
            if (noc_rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_vld", bus.flit_valid, 1);
                    chk("hold_flit", bus.flit, prev_flit);
                end
                if (bus.flit_valid && !bus.flit_ready) chk("bp_pl_ready", bus.pl_ready, 0);
                if (bus.pl_valid && bus.pl_ready) begin
                    pl_taken = 1;
                    pl_cnt++;
                end
                if (bus.flit_valid && bus.flit_ready) begin
                    if (exp_q.size() == 0) chk("extra_flit", exp_q.size(), 1);
                    else chk("flit", bus.flit, exp_q.pop_front());
                    if (flit_idx == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    flit_idx++;
                end
                prev_stall = bus.flit_valid && !bus.flit_ready;
                prev_flit  = bus.flit;
            end
        end
    end

    // Payload source and router ready.
    initial begin
        bus.pl_valid   = 1'b0;
        bus.pl_data    = '0;
        bus.flit_ready = 1'b1;
        forever begin
            @(posedge noc_clk);
            #2;
            if (pl_taken) begin
                if (pl_q.size() > 0) pl_q.delete(0);
                pl_taken = 0;
            end
            bus.flit_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pl_q.size() > 0 && (!pl_rand || $urandom_range(0, 3) != 0)) begin
                bus.pl_valid = 1'b1;
                bus.pl_data  = pl_q[0];
            end else begin
                bus.pl_valid = 1'b0;
                bus.pl_data  = $urandom;
            end
        end
    end

    task automatic do_packet(input int dx, input int dy, input int sx, input int sy,
                             input int len_req, input logic [VC_NUM-1:0] mask,
                             input int hold0, input bit tchk, input int abort_at);
        int len, vc;
        bit ok;
        logic [DATA_W-1:0] w, hd;
        logic [1:0] t;
        len     = (len_req > MAX_LEN) ? MAX_LEN : len_req;
        vc      = rr_pick(rr_last, mask);
        rr_last = vc;
        @(posedge noc_clk);
        #1;
        exp_q.delete();
        pl_q.delete();
        pl_taken = 0;
        flit_idx = 0;
        pl_cnt   = 0;
        hd = DATA_W'(dx + dy * 4 + sx * 16 + sy * 64 + len * 256);
        t  = (len == 0) ? 2'b11 : 2'b00;
        exp_q.push_back({t, VC_W'(vc), hd});
        // Two spare words are offered so over-consumption is visible.
        for (int k = 0; k < len + 2; k++) begin
            w = $urandom;
            pl_q.push_back(w);
            if (k < len) exp_q.push_back({(k == len - 1) ? 2'b10 : 2'b01, VC_W'(vc), w});
        end
        bus.src_x      = ID_X_W'(sx);
        bus.src_y      = ID_Y_W'(sy);
        bus.req_dest_x = ID_X_W'(dx);
        bus.req_dest_y = ID_Y_W'(dy);
        bus.req_len    = LEN_W'(len_req);
        bus.vc_ready   = (hold0 > 0) ? '0 : mask;
        bus.req_valid  = 1'b1;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge noc_clk);
            if (bus.req_ready) begin
                ok      = 1;
                req_cyc = cyc;
            end
        end
        chk("req_hs", ok, 1);
        @(posedge noc_clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_len   = LEN_W'($urandom_range(0, 31));
        if (hold0 > 0) begin
            for (int c = 0; c < hold0; c++) begin
                chk("alloc_fv", bus.flit_valid, 0);
                chk("alloc_rr", bus.req_ready, 0);
                @(posedge noc_clk);
                #1;
            end
            bus.vc_ready = mask;
        end
        if (abort_at > 0) begin
            ok = 0;
            for (int c = 0; c < 200 && !ok; c++) begin
                @(posedge noc_clk);
                #1;
                if (flit_idx >= abort_at) ok = 1;
            end
            chk("abort_reach", ok, 1);
            noc_rst = 1'b1;
            @(posedge noc_clk);
            #1;
            noc_rst = 1'b0;
            chk("rst_fv", bus.flit_valid, 0);
            chk("rst_rr", bus.req_ready, 1);
            chk("rst_cnt", bus.tx_pkt_cnt, 0);
            exp_q.delete();
            pl_q.delete();
            pl_taken = 0;
            rr_last  = VC_NUM - 1;
            pkt_exp  = 0;
            return;
        end
        ok = 0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(posedge noc_clk);
            #1;
            if (exp_q.size() == 0 && !bus.flit_valid) ok = 1;
        end
        chk("pkt_done", ok, 1);
        pkt_exp++;
        chk("pkt_cnt", bus.tx_pkt_cnt, 16'(pkt_exp));
        chk("pl_cnt", pl_cnt, len);
        chk("idle_rr", bus.req_ready, 1);
        if (tchk) begin
            chk("lat_head", first_cyc, req_cyc + 2);
            chk("lat_tail", last_cyc, req_cyc + 2 + len);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        noc_rst        = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_dest_x = '0;
        bus.req_dest_y = '0;
        bus.req_len    = '0;
        bus.src_x      = '0;
        bus.src_y      = '0;
        bus.vc_ready   = '0;
        bp = 0;
        pl_rand = 0;
        rr_last = VC_NUM - 1;
        pkt_exp = 0;
        flit_idx = 0;
        pl_cnt = 0;
        repeat (3) @(posedge noc_clk);
        #1;
        noc_rst = 1'b0;
        chk("rst_flit_valid", bus.flit_valid, 0);
        chk("rst_flit", bus.flit, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_pl_ready", bus.pl_ready, 0);
        chk("rst_tx_cnt", bus.tx_pkt_cnt, 0);

        do_packet(2, 1, 0, 0, 3, 2'b11, 0, 1, 0);
        do_packet(1, 3, 0, 0, 5, 2'b11, 0, 1, 0);
        do_packet(3, 0, 1, 2, 0, 2'b11, 0, 1, 0);
        do_packet(0, 2, 1, 1, 2, 2'b10, 5, 0, 0);
        bp = 1;
        pl_rand = 1;
        do_packet(1, 1, 2, 2, 16, 2'b11, 0, 0, 0);
        do_packet(2, 2, 3, 3, 31, 2'b01, 0, 0, 0);
        for (int n = 0; n < 20; n++) begin
            bp      = 1'($urandom_range(0, 1));
            pl_rand = 1'($urandom_range(0, 1));
            do_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 18),
                      VC_NUM'($urandom_range(1, 3)), 0, 0, 0);
        end
        bp = 0;
        pl_rand = 0;
        do_packet(1, 2, 0, 0, 8, 2'b11, 0, 0, 2);
        do_packet(3, 3, 1, 0, 1, 2'b11, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
